dtcm_ctrl: RTL and testbench
============================

Name: dtcm_ctrl

Overview:
- Data TCM controller directly downstream of the core's LSU.
- Consumes the lsu2dtcm command channel (valid/ready, read, addr, wdata, wmask) and performs the access on an internal single-port word SRAM with a byte-write mask.
- Returns one response per accepted command on the rsp channel, in order.
- A 2-entry output stage (RAM output register plus skid) sustains one access per cycle under rsp backpressure.

Parameters:
- DTCM_ADDR_WIDTH, 16, byte address width; RAM depth = 2^(DTCM_ADDR_WIDTH-2) words.
- XLEN, 32, data width in bits; wmask width = XLEN/8.
- RAM_DEPTH, 2^(DTCM_ADDR_WIDTH-2), implemented words; may be smaller than the address space.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command valid from LSU
- cmd_ready  out  1  command accept
- cmd_read  in  1  1 = read, 0 = write
- cmd_addr  in  DTCM_ADDR_WIDTH  byte address; bits [1:0] ignored
- cmd_wdata  in  XLEN  write data
- cmd_wmask  in  XLEN/8  byte write enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept from LSU
- rsp_rdata  out  XLEN  read data; 0 for write responses
- rsp_err  out  1  address-error flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): s1_valid=0, skid_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1. RAM contents are not cleared.
- Command accept: cmd_valid & cmd_ready at a rising edge.
- Word index = cmd_addr[DTCM_ADDR_WIDTH-1:2].
- Write: at the accept edge, the RAM word is updated only for bytes where wmask[i]=1. wmask=0 is a legal no-op write and still produces a response.
- Read: the RAM word is captured into s1_data at the accept edge. A read issued the cycle after a write to the same word returns the new data.
- Each accepted command loads stage s1 (valid, data, err) at the accept edge. Response latency is 1 cycle: rsp_valid=1 in the cycle after accept.
- Output selection: rsp_valid = skid_valid | s1_valid. If skid_valid, rsp_* come from skid (older entry); otherwise from s1.
- cmd_ready = !skid_valid. This is a registered term with no combinational path from rsp_ready.
- Per-edge state update (pop = rsp_valid & rsp_ready; acc = command accept):
  - skid holds, pop: skid cleared; s1 unchanged. acc is impossible in this state.
  - no skid, s1 valid, pop, acc: s1 reloaded with the new command.
  - no skid, s1 valid, pop, no acc: s1 cleared.
  - no skid, s1 valid, no pop, acc: s1 moves to skid; new command loads s1.
  - no skid, s1 valid, no pop, no acc: hold.
  - s1 empty, acc: s1 loaded.
- Throughput: with rsp_ready held high, 1 command per cycle indefinitely.
- Ordering: responses are always in command order. At most 2 responses are outstanding.
- rsp payload is held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: pending responses are discarded. Writes already accepted remain in RAM.

Optional Feature:
- Macro: DTCM_ADDR_CHK_EN.
- Defined:
  - An access whose word index >= RAM_DEPTH is flagged: the write is suppressed, read data is 0, and rsp_err=1 with that response.
  - The command is still accepted with normal latency and ordering.
- Undefined:
  - The index wraps modulo RAM_DEPTH (upper bits dropped).
  - rsp_err is tied to 0.

Test Plan:
- Write then read: write addr 0x0010, wdata 0xDEADBEEF, wmask 0xF; next cycle read 0x0010 -> write rsp rdata 0; read rsp one cycle after accept with rdata 0xDEADBEEF.
- Byte mask: after the above, write 0x0010, wdata 0x11223344, wmask 0x5; read 0x0010 -> 0xDE22BE44.
- Back-to-back streaming: rsp_ready=1, reads of 0x0000, 0x0004, 0x0008, 0x000C on consecutive cycles (RAM preloaded with 0xA0..0xA3) -> cmd_ready stays 1; rsp_valid=1 for 4 consecutive cycles with data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Backpressure: rsp_ready=0 with continuous reads -> 2 commands accepted, then cmd_ready=0. rsp_rdata holds the first read's data. Raise rsp_ready -> first then second response; cmd_ready returns to 1 the cycle after skid drains.
- Reset mid-flight: assert rst with s1 and skid both valid -> rsp_valid=0 and cmd_ready=1 immediately (async). After release, a read of a previously written word returns the written value.
- Address check (DTCM_ADDR_CHK_EN, RAM_DEPTH=1024): write 0x1000 -> rsp_err=1 and RAM unchanged; read 0x1000 -> rdata 0, rsp_err=1. Without the macro, a read of 0x1000 returns word 0 and rsp_err=0.

Source files
------------

// File: rtl/dtcm_ctrl.sv
// rtl/dtcm_ctrl.sv - data TCM controller: LSU command channel to single-port word SRAM with in-order responses
//
// Purpose: accepts one load/store per cycle from the LSU. Each access is done on an
// internal byte-maskable word SRAM, and one response per command is returned in order.
// A 2-entry output stage (s1 + skid) keeps full throughput under response backpressure.
//
// Optional feature macro: DTCM_ADDR_CHK_EN
//   defined   - word index >= RAM_DEPTH is flagged: write suppressed, read data 0, rsp_err=1
//   undefined - word index wraps modulo RAM_DEPTH, rsp_err tied to 0
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake from the LSU
//   cmd_read                 1 = read, 0 = write
//   cmd_addr                 byte address (bits [1:0] ignored)
//   cmd_wdata, cmd_wmask     write data and byte enables
//   rsp_valid/rsp_ready      response handshake to the LSU
//   rsp_rdata                read data (0 for writes)
//   rsp_err                  address-error flag
//
// RAM_DEPTH is assumed to be a power of two; wrapping keeps the low index bits.

module dtcm_ctrl #(
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int XLEN            = 32,
  parameter int RAM_DEPTH       = 2 ** (DTCM_ADDR_WIDTH - 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_read,
  input  logic [DTCM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [XLEN-1:0]            cmd_wdata,
  input  logic [XLEN/8-1:0]          cmd_wmask,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_rdata,
  output logic                       rsp_err
);

  localparam int MASK_W = XLEN / 8;
  localparam int WIDX_W = DTCM_ADDR_WIDTH - 2;
  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [XLEN-1:0]   mem [RAM_DEPTH];

  logic [WIDX_W-1:0] word_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              addr_err;
  logic              acc;
  logic              pop;
  logic [XLEN-1:0]   new_data;

  logic              s1_valid;
  logic [XLEN-1:0]   s1_data;
  logic              s1_err;
  logic              skid_valid;
  logic [XLEN-1:0]   skid_data;
  logic              skid_err;

  logic              unused_bits;

  assign word_idx = cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign ram_idx  = word_idx[RAM_AW-1:0];

`ifdef DTCM_ADDR_CHK_EN
  assign addr_err = (int'(word_idx) >= RAM_DEPTH);
`else
  assign addr_err = 1'b0;
`endif

  assign unused_bits = ^{cmd_addr[1:0], word_idx};

  // cmd_ready depends only on registered state, so there is no path from rsp_ready.
  assign cmd_ready = !skid_valid;
  assign acc       = cmd_valid && cmd_ready;
  assign rsp_valid = skid_valid || s1_valid;
  assign pop       = rsp_valid && rsp_ready;

  // Reading the array at the accept edge sees any write from the previous edge.
  assign new_data = (cmd_read && !addr_err) ? mem[ram_idx] : '0;

  // Skid always holds the older entry when both are valid.
  assign rsp_rdata = skid_valid ? skid_data : s1_data;
  assign rsp_err   = skid_valid ? skid_err  : s1_err;

  // RAM is not reset: accepted writes survive a controller reset.
  always_ff @(posedge clk) begin
    if (acc && !cmd_read && !addr_err) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (cmd_wmask[i]) begin
          mem[ram_idx][8*i +: 8] <= cmd_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_err     <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (skid_valid) begin
      // No accept is possible here; s1 waits behind the skid entry.
      if (pop) begin
        skid_valid <= 1'b0;
      end
    end else if (s1_valid) begin
      if (acc && !pop) begin
        skid_valid <= 1'b1;
        skid_data  <= s1_data;
        skid_err   <= s1_err;
        s1_data    <= new_data;
        s1_err     <= addr_err;
      end else if (acc && pop) begin
        s1_data    <= new_data;
        s1_err     <= addr_err;
      end else if (pop) begin
        s1_valid   <= 1'b0;
      end
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_data  <= new_data;
      s1_err   <= addr_err;
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// tb/tb_dtcm_ctrl.sv - self-checking bench for dtcm_ctrl against a queue-based reference model

module tb_dtcm_ctrl;

  localparam int AW    = 16;
  localparam int XL    = 32;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [XL-1:0] cmd_wdata;
  logic [3:0]    cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [XL-1:0] rsp_rdata;
  logic          rsp_err;

  dtcm_ctrl #(
    .DTCM_ADDR_WIDTH(AW),
    .XLEN(XL),
    .RAM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_read(cmd_read),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mm [DEPTH];
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance.
  task automatic cyc(input bit v, input bit rd, input logic [15:0] a,
                     input logic [31:0] wd, input logic [3:0] wm, input bit rr);
    bit   acc_m;
    bit   pop_m;
    int   idx;
    rsp_t e;
    cmd_valid = v;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
    rsp_ready = rr;
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, q.size() < 2});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("rsp_rdata", rsp_rdata, q[0].data);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
    end
    pop_m = (q.size() > 0) && rr;
    acc_m = v && (q.size() < 2);
    e.data = 32'h0;
    e.err  = 1'b0;
    if (acc_m) begin
      idx = int'(a) / 4;
`ifdef DTCM_ADDR_CHK_EN
      e.err = (idx >= DEPTH);
`endif
      idx = idx % DEPTH;
      if (rd) begin
        e.data = e.err ? 32'h0 : mm[idx];
      end else if (!e.err) begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk);
    if (pop_m) void'(q.pop_front());
    if (acc_m) q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int w;
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload words 0..15; words 0..3 hold 0xA0..0xA3.
    for (int k = 0; k < 16; k++)
      cyc(1, 0, 16'(k * 4), (k < 4) ? 32'(32'hA0 + k) : $urandom, 4'hF, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Write then read the same word on consecutive cycles, then a byte-masked write.
    cyc(1, 0, 16'h0010, 32'hDEADBEEF, 4'hF, 1);
    cyc(1, 1, 16'h0010, 32'h0, 4'h0, 1);
    cyc(1, 0, 16'h0010, 32'h11223344, 4'h5, 1);
    cyc(1, 1, 16'h0010, 32'h0, 4'h0, 1);
    cyc(1, 0, 16'h0014, 32'hFFFFFFFF, 4'h0, 1);
    cyc(1, 1, 16'h0014, 32'h0, 4'h0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Back-to-back streaming reads.
    for (int k = 0; k < 4; k++) cyc(1, 1, 16'(k * 4), 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1);

    // Backpressure: two accepts, then stall; release and drain.
    for (int k = 0; k < 5; k++) cyc(1, 1, 16'(k * 4), 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 16'(32 + k * 4), 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1);

    // Address 0x1000: wraps to word 0 or is flagged, depending on the build.
    cyc(1, 0, 16'h1000, 32'h5A5A5A5A, 4'hF, 1);
    cyc(1, 1, 16'h1000, 0, 0, 1);
    cyc(1, 1, 16'h0000, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      w = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) w += 1024;
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 16'(w * 4),
          $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 2) != 0));
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1);

    // Reset with s1 and skid both full, then confirm RAM contents survived.
    cyc(1, 1, 16'h0004, 0, 0, 0);
    cyc(1, 1, 16'h0008, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 16'h0010, 0, 0, 1);
    cyc(1, 1, 16'h0014, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
